// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender with a registered two-entry skid-buffer output.
// Modes: 00 zero-extend, 01 sign-extend, 10 upper load, 11 sign-extend << 2 (branch offset).
// Optional delivered-result counter enabled by defining IMM_EXT_PERF_CNT_EN; when the
// macro is undefined there is no counter register and ext_cnt is tied to zero.
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] ext_out,
   output logic [31:0]      ext_cnt
);

   // The branch mode shifts the sign-extended value left by 2, which needs two spare bits.
   if (OUT_W <= IN_W + 1) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be greater than IN_W + 1");
   end

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull
   } state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_in_ready;
   logic [OUT_W-1:0]   r_out;
   logic [OUT_W-1:0]   r_skid;
   logic [OUT_W-1:0]   w_sext;
   logic [OUT_W-1:0]   w_ext;
   logic               w_accept;
   logic               w_xfer;

   // Flush kills both handshakes so nothing is stored or counted in the flush cycle.
   assign w_accept  = in_valid && r_in_ready && !flush;
   assign w_xfer    = out_valid && out_ready && !flush;
   assign w_sext    = {{(OUT_W - IN_W){imm[IN_W-1]}}, imm};

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != StEmpty);
   assign ext_out   = r_out;

   // Extension result for the incoming immediate; storage only ever holds this value.
   always_comb begin
      w_ext = '0;
      case (mode)
         2'b00:   w_ext = {{(OUT_W - IN_W){1'b0}}, imm};
         2'b01:   w_ext = w_sext;
         2'b10:   w_ext = {imm, {(OUT_W - IN_W){1'b0}}};
         default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
      endcase
   end

   // Next-state logic of the skid buffer occupancy.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = StEmpty;
      end else begin
         case (r_state)
            StEmpty: if (w_accept) w_state_nxt = StOne;
            StOne: begin
               if (w_accept && !w_xfer) begin
                  w_state_nxt = StFull;
               end else if (!w_accept && w_xfer) begin
                  w_state_nxt = StEmpty;
               end
            end
            StFull:  if (w_xfer) w_state_nxt = StOne;
            default: w_state_nxt = StEmpty;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // in_ready registered from next state so out_ready never reaches it combinationally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_in_ready <= 1'b0;
      end else begin
         r_in_ready <= (w_state_nxt != StFull);
      end
   end

   // Output and skid registers; the skid entry moves forward when the output drains.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out  <= '0;
         r_skid <= '0;
      end else if (!flush) begin
         case (r_state)
            StEmpty: begin
               if (w_accept) r_out <= w_ext;
            end
            StOne: begin
               if (w_accept && w_xfer) begin
                  r_out <= w_ext;
               end else if (w_accept) begin
                  r_skid <= w_ext;
               end
            end
            StFull: begin
               if (w_xfer) r_out <= r_skid;
            end
            default: ;
         endcase
      end
   end

`ifdef IMM_EXT_PERF_CNT_EN
   logic [31:0] r_cnt;

   // Delivered-result counter, wraps naturally at 32 bits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= 32'd0;
      end else if (w_xfer) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign ext_cnt = r_cnt;
`else
   assign ext_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: scenario tasks with a queue-based reference model.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] imm = '0;
   logic [1:0]  mode = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ext_out;
   logic [31:0] ext_cnt;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] mq[$];
   logic [31:0] mcnt = 32'd0;

   imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext_out   (ext_out),
      .ext_cnt   (ext_cnt)
   );

   always #5 clk = ~clk;

   // Reference extension computed with plain integer arithmetic.
   function automatic logic [31:0] ref_ext(input logic [15:0] im, input logic [1:0] md);
      longint u;
      longint s;
      u = longint'(im);
      s = (u >= 32768) ? u - 65536 : u;
      case (md)
         2'b00:   return 32'(u);
         2'b01:   return 32'(s);
         2'b10:   return 32'(u * 65536);
         default: return 32'(s * 4);
      endcase
   endfunction

   function automatic logic [31:0] exp_cnt();
`ifdef IMM_EXT_PERF_CNT_EN
      return mcnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic drive(input logic v, input logic [15:0] im, input logic [1:0] md,
                        input logic ordy, input logic fl);
      in_valid  = v;
      imm       = im;
      mode      = md;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   // Advance the model by one cycle from the current inputs, then clock the DUT.
   task automatic tick();
      logic acc;
      logic xfr;
      if (flush) begin
         mq.delete();
      end else begin
         acc = in_valid && (mq.size() < 2);
         xfr = (mq.size() > 0) && out_ready;
         if (xfr) begin
            void'(mq.pop_front());
            mcnt = mcnt + 32'd1;
         end
         if (acc) mq.push_back(ref_ext(imm, mode));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      resetn    = 1'b0;
      mq.delete();
      mcnt      = 32'd0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
      end
      checks++;
      if (ext_out !== 32'd0) begin
         errors++; $display("FAIL rst_ext_out got=%h want=0", ext_out);
      end
      checks++;
      if (ext_cnt !== 32'd0) begin
         errors++; $display("FAIL rst_ext_cnt got=%h want=0", ext_cnt);
      end
      @(posedge clk);
      #1 resetn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_rdy_before_edge got=%b want=0", in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL rst_rdy_after_edge got=%b want=1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid_after_edge got=%b want=0", out_valid);
      end
   endtask

   task automatic test_mode_sweep();
      logic [15:0] vimm[4];
      logic [1:0]  vmode[4];
      logic [31:0] vexp[4];
      vimm  = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
      vmode = '{2'b00, 2'b01, 2'b10, 2'b11};
      vexp  = '{32'h0000_8000, 32'hFFFF_8000, 32'h1234_0000, 32'hFFFF_FFFC};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vimm[i], vmode[i], 1'b1, 1'b0);
         tick();
         drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL sweep_valid[%0d] got=%b want=1", i, out_valid);
         end
         checks++;
         if (ext_out !== vexp[i]) begin
            errors++; $display("FAIL sweep_value[%0d] got=%h want=%h", i, ext_out, vexp[i]);
         end
         tick();
      end
      checks++;
      if (ext_cnt !== exp_cnt()) begin
         errors++; $display("FAIL sweep_cnt got=%0d want=%0d", ext_cnt, exp_cnt());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] bexp[3];
      logic [31:0] got[$];
      logic        c_pend;
      logic        c_acc;
      bexp   = '{ref_ext(16'h8001, 2'b01), ref_ext(16'h0F0F, 2'b10), ref_ext(16'h4001, 2'b11)};
      drive(1'b1, 16'h8001, 2'b01, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_rdy_a got=%b want=1", in_ready);
      end
      tick();
      drive(1'b1, 16'h0F0F, 2'b10, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_rdy_b got=%b want=1", in_ready);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h4001, 2'b11, 1'b0, 1'b0);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_rdy_full[%0d] got=%b want=0", i, in_ready);
         end
         checks++;
         if (out_valid !== 1'b1 || ext_out !== bexp[0]) begin
            errors++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/%h", i, out_valid, ext_out,
                               bexp[0]);
         end
         tick();
      end
      c_pend = 1'b1;
      for (int i = 0; i < 8 && got.size() < 3; i++) begin
         drive(c_pend, 16'h4001, 2'b11, 1'b1, 1'b0);
         if (out_valid === 1'b1) got.push_back(ext_out);
         c_acc = c_pend && (mq.size() < 2);
         tick();
         if (c_acc) c_pend = 1'b0;
      end
      checks++;
      if (got.size() !== 3) begin
         errors++; $display("FAIL bp_count got=%0d want=3", got.size());
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= got.size()) begin
            errors++; $display("FAIL bp_order[%0d] got=none want=%h", i, bexp[i]);
         end else if (got[i] !== bexp[i]) begin
            errors++; $display("FAIL bp_order[%0d] got=%h want=%h", i, got[i], bexp[i]);
         end
      end
      drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drained got=%b want=0", out_valid);
      end
   endtask

   task automatic test_stream();
      int delivered;
      int rdy_low;
      int bad_val;
      delivered = 0;
      rdy_low   = 0;
      bad_val   = 0;
      do_reset();
      for (int i = 0; i < 101; i++) begin
         drive(i < 100, 16'($urandom), 2'($urandom), 1'b1, 1'b0);
         if (i < 100 && in_ready !== 1'b1) rdy_low++;
         if (out_valid === 1'b1) begin
            delivered++;
            if (mq.size() == 0 || ext_out !== mq[0]) bad_val++;
         end else if (i > 0) begin
            bad_val++;
         end
         tick();
      end
      checks++;
      if (delivered !== 100) begin
         errors++; $display("FAIL stream_count got=%0d want=100", delivered);
      end
      checks++;
      if (rdy_low !== 0) begin
         errors++; $display("FAIL stream_rdy_low got=%0d want=0", rdy_low);
      end
      checks++;
      if (bad_val !== 0) begin
         errors++; $display("FAIL stream_values bad=%0d want=0", bad_val);
      end
      checks++;
      if (ext_cnt !== exp_cnt()) begin
         errors++; $display("FAIL stream_cnt got=%0d want=%0d", ext_cnt, exp_cnt());
      end
   endtask

   task automatic test_flush();
      logic [31:0] wexp;
      logic [31:0] cnt_before;
      wexp = ref_ext(16'h7777, 2'b10);
      drive(1'b1, 16'h1111, 2'b00, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h2222, 2'b01, 1'b0, 1'b0);
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL flush_full_rdy got=%b want=0", in_ready);
      end
      cnt_before = exp_cnt();
      drive(1'b1, 16'h3333, 2'b11, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid[%0d] got=%b want=0", i, out_valid);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_rdy[%0d] got=%b want=1", i, in_ready);
         end
         tick();
      end
      checks++;
      if (ext_cnt !== cnt_before) begin
         errors++; $display("FAIL flush_cnt got=%0d want=%0d", ext_cnt, cnt_before);
      end
      drive(1'b1, 16'h7777, 2'b10, 1'b1, 1'b0);
      tick();
      drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || ext_out !== wexp) begin
         errors++; $display("FAIL flush_after got=%b/%h want=1/%h", out_valid, ext_out, wexp);
      end
      tick();
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) < 7, 16'($urandom), 2'($urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
         if (out_valid !== (mq.size() > 0)) bad++;
         if (in_ready !== (mq.size() < 2)) bad++;
         if (mq.size() > 0 && ext_out !== mq[0]) bad++;
         if (ext_cnt !== exp_cnt()) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL random_model bad=%0d want=0", bad);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 20 && mcnt < 5; i++) begin
         drive(1'b1, 16'($urandom), 2'($urandom), 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 16'h5A5A, 2'b01, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || ext_cnt !== exp_cnt() || mcnt !== 32'd5) begin
         errors++; $display("FAIL ares_pre got=%b/%0d want=1/%0d", out_valid, ext_cnt, exp_cnt());
      end
      #1 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ext_out !== 32'd0 || ext_cnt !== 32'd0 || in_ready !== 1'b0)
      begin
         errors++; $display("FAIL ares_now got=%b/%h/%0d/%b want=0/0/0/0", out_valid, ext_out,
                            ext_cnt, in_ready);
      end
      @(posedge clk);
      #1;
      do_reset();
   endtask

   task automatic test_wrap();
      do_reset();
`ifdef IMM_EXT_PERF_CNT_EN
      force dut.r_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_cnt;
      mcnt = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (ext_cnt !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL wrap_preload got=%h want=ffffffff", ext_cnt);
      end
`endif
      drive(1'b1, 16'hABCD, 2'b00, 1'b1, 1'b0);
      tick();
      drive(1'b0, 16'h0, 2'b00, 1'b1, 1'b0);
      tick();
      checks++;
      if (ext_cnt !== exp_cnt() || ext_cnt !== 32'd0) begin
         errors++; $display("FAIL wrap_cnt got=%h want=%h", ext_cnt, exp_cnt());
      end
   endtask

   initial begin
      test_reset();
      test_mode_sweep();
      test_backpressure();
      test_stream();
      test_flush();
      test_random();
      test_async_reset();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
